// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, position width and decoder FSM state type.
package vga_timing_pkg;

  localparam int unsigned POS_W = 11;
  localparam int unsigned CNT_W = 4;

  localparam logic [POS_W-1:0] H_ACTIVE     = 11'd640;
  localparam logic [POS_W-1:0] H_SYNC_START = 11'd704;
  localparam logic [POS_W-1:0] H_TOTAL      = 11'd800;
  localparam logic [POS_W-1:0] V_ACTIVE     = 11'd480;
  localparam logic [POS_W-1:0] V_SYNC_START = 11'd523;
  localparam logic [POS_W-1:0] V_TOTAL      = 11'd525;
  localparam logic [CNT_W-1:0] LOCK_LINES   = 4'd4;
  localparam logic [CNT_W-1:0] LOSS_COUNT   = 4'd3;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;

  // Modulo-total increment of a position counter.
  function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] cur,
                                               input logic [POS_W-1:0] total);
    pos_inc = (cur == total - 11'd1) ? '0 : cur + 11'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus delay flop; flags a falling edge of an idle-high sync input.
module sync_edge_detect (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Sync,
  output logic o_Fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  // Resynchronize the input and keep one cycle of history; idle level is high.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= i_Sync;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  // High for one cycle, consumed by the second clock edge after the input is first sampled low.
  assign o_Fall = dly_q & ~sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Locks to an incoming HSync/VSync pair and regenerates pixel position and active-video flags.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter logic [POS_W-1:0] P_H_ACTIVE     = H_ACTIVE,
  parameter logic [POS_W-1:0] P_H_SYNC_START = H_SYNC_START,
  parameter logic [POS_W-1:0] P_H_TOTAL      = H_TOTAL,
  parameter logic [POS_W-1:0] P_V_ACTIVE     = V_ACTIVE,
  parameter logic [POS_W-1:0] P_V_SYNC_START = V_SYNC_START,
  parameter logic [POS_W-1:0] P_V_TOTAL      = V_TOTAL,
  parameter logic [CNT_W-1:0] P_LOCK_LINES   = LOCK_LINES,
  parameter logic [CNT_W-1:0] P_LOSS_COUNT   = LOSS_COUNT
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_HSync,
  input  logic             i_VSync,
  output logic [POS_W-1:0] o_HPos,
  output logic [POS_W-1:0] o_VPos,
  output logic             o_Active,
  output logic             o_Locked,
  output logic             o_FrameStart,
  output logic             o_SyncErr
);

  // The H edge is seen two clocks after the first low sample, so the
  // counter is loaded two ahead of the sync start position.
  localparam logic [POS_W-1:0] H_LOAD  = P_H_SYNC_START + 11'd2;
  localparam logic [POS_W-1:0] H_CHECK = P_H_SYNC_START + 11'd1;

  logic [1:0] sync_raw;
  logic [1:0] sync_fall;
  logic       h_edge;
  logic       v_edge;

  assign sync_raw = {i_VSync, i_HSync};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    sync_edge_detect u_edge (
      .i_Clk  (i_Clk),
      .i_Rst_n(i_Rst_n),
      .i_Sync (sync_raw[gi]),
      .o_Fall (sync_fall[gi])
    );
  end

  assign h_edge = sync_fall[0];
  assign v_edge = sync_fall[1];

  sync_state_e      state_q, state_d;
  logic [POS_W-1:0] h_cnt_q, h_cnt_d;
  logic [POS_W-1:0] v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             v_seen_q, v_seen_d;
  logic             missed_q, missed_d;
  logic             active_q, active_d;
  logic             locked_q, locked_d;
  logic             frame_start_q, frame_start_d;
  logic             sync_err_q, sync_err_d;

  logic h_good;
  logic v_good;
  logic h_err;
  logic v_err;

  // Next-state logic: free-running counters, edge alignment, lock tracking.
  always_comb begin
    state_d    = state_q;
    h_cnt_d    = pos_inc(h_cnt_q, P_H_TOTAL);
    v_cnt_d    = v_cnt_q;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    v_seen_d   = v_seen_q;
    missed_d   = missed_q;
    sync_err_d = 1'b0;
    h_err      = 1'b0;
    v_err      = 1'b0;

    if (h_cnt_q == P_H_TOTAL - 11'd1) begin
      v_cnt_d = pos_inc(v_cnt_q, P_V_TOTAL);
    end

    h_good = (h_cnt_q == H_CHECK);
    v_good = (v_cnt_q == P_V_SYNC_START);

    case (state_q)
      SEARCH: begin
        good_cnt_d = '0;
        err_cnt_d  = '0;
        v_seen_d   = 1'b0;
        missed_d   = 1'b0;
        if (h_edge) begin
          h_cnt_d = H_LOAD;
          state_d = ACQUIRE;
        end
      end

      ACQUIRE: begin
        err_cnt_d = '0;
        missed_d  = 1'b0;
        if (h_edge) begin
          if (h_good) begin
            if (good_cnt_q < P_LOCK_LINES) begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end else begin
            h_cnt_d    = H_LOAD;
            good_cnt_d = '0;
          end
        end
        if (v_edge) begin
          if (!v_seen_q) begin
            v_cnt_d  = P_V_SYNC_START;
            v_seen_d = 1'b1;
          end else if (!v_good) begin
            v_cnt_d  = P_V_SYNC_START;
            v_seen_d = 1'b0;
          end
        end
        if ((good_cnt_d >= P_LOCK_LINES) && v_seen_d) begin
          state_d = LOCKED;
        end
      end

      LOCKED: begin
        if (h_edge) begin
          missed_d = 1'b0;
          if (!h_good) begin
            h_cnt_d = H_LOAD;
            // A late edge right after a declared miss is the same fault: realign only.
            h_err   = !missed_q;
          end
        end else if (h_good) begin
          h_err    = 1'b1;
          missed_d = 1'b1;
        end
        if (v_edge && !v_good) begin
          v_cnt_d = P_V_SYNC_START;
          v_err   = 1'b1;
        end
        if (h_err || v_err) begin
          sync_err_d = 1'b1;
          err_cnt_d  = err_cnt_q + 4'd1;
          if (err_cnt_d >= P_LOSS_COUNT) begin
            state_d    = SEARCH;
            err_cnt_d  = '0;
            good_cnt_d = '0;
            v_seen_d   = 1'b0;
            missed_d   = 1'b0;
          end
        end else if ((h_edge && h_good) || (v_edge && v_good)) begin
          err_cnt_d = '0;
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase

    // Qualifiers are computed from next-state counters so they line up with o_HPos/o_VPos.
    locked_d      = (state_d == LOCKED);
    active_d      = locked_d && (h_cnt_d < P_H_ACTIVE) && (v_cnt_d < P_V_ACTIVE);
    frame_start_d = locked_d && (h_cnt_d == '0) && (v_cnt_d == '0);
  end

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= SEARCH;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      good_cnt_q    <= '0;
      err_cnt_q     <= '0;
      v_seen_q      <= 1'b0;
      missed_q      <= 1'b0;
      active_q      <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      good_cnt_q    <= good_cnt_d;
      err_cnt_q     <= err_cnt_d;
      v_seen_q      <= v_seen_d;
      missed_q      <= missed_d;
      active_q      <= active_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign o_HPos       = h_cnt_q;
  assign o_VPos       = v_cnt_q;
  assign o_Active     = active_q;
  assign o_Locked     = locked_q;
  assign o_FrameStart = frame_start_q;
  assign o_SyncErr    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder driven by a behavioural 800x525 sync generator.
module tb_vga_sync_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic        active;
  logic        locked;
  logic        fs;
  logic        serr;

  vga_sync_decoder dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_HSync     (hsync),
    .i_VSync     (vsync),
    .o_HPos      (hpos),
    .o_VPos      (vpos),
    .o_Active    (active),
    .o_Locked    (locked),
    .o_FrameStart(fs),
    .o_SyncErr   (serr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Generator position currently driven on the sync inputs.
  int gh = 0;
  int gv = 0;
  bit hs_stuck = 1'b0;
  bit chk_pos = 1'b0;

  // Per-scenario observation counters.
  int n_err = 0;
  int n_fs = 0;
  int n_act = 0;
  int n_lock = 0;
  int n_unl = 0;
  int n_posbad = 0;

  task automatic clear_counts();
    n_err = 0; n_fs = 0; n_act = 0; n_lock = 0; n_unl = 0; n_posbad = 0;
  endtask

  // Drive the generator's sync levels for (gv,gh), clock once, sample #1 later.
  task automatic step();
    hsync = hs_stuck ? 1'b1 : !(gh >= 704 && gh < 768);
    vsync = !(gv >= 523);
    @(posedge clk);
    #1;
    n_err  += int'(serr);
    n_fs   += int'(fs);
    n_act  += int'(active);
    n_lock += int'(locked);
    n_unl  += int'(!locked);
    if (chk_pos && (hpos !== 11'(gh) || vpos !== 11'(gv))) n_posbad++;
  endtask

  task automatic next_pos();
    gh++;
    if (gh == 800) begin
      gh = 0;
      gv = (gv == 524) ? 0 : gv + 1;
    end
  endtask

  task automatic start_at(input int v, input int h);
    gv = v;
    gh = h;
    step();
  endtask

  // Advance the generator until (tv,th) has been driven and sampled.
  task automatic run_until(input int tv, input int th);
    int guard;
    guard = 0;
    while (!(gv == tv && gh == th)) begin
      next_pos();
      step();
      guard++;
      if (guard > 450000) begin
        total++;
        bad++;
        $display("FAIL run_until: got v=%0d h=%0d want v=%0d h=%0d", gv, gh, tv, th);
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int nz;
    nz = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 24; i++) begin
      hsync = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (hpos != 0 || vpos != 0 || active || locked || fs || serr) nz++;
    end
    total++; if (nz !== 0) begin bad++; $display("FAIL reset_hold: got %0d nonzero cycles want 0", nz); end
    total++; if (hpos !== 11'd0) begin bad++; $display("FAIL reset_hpos: got %0d want 0", hpos); end
    total++; if (vpos !== 11'd0) begin bad++; $display("FAIL reset_vpos: got %0d want 0", vpos); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %0b want 0", active); end
    total++; if (fs !== 1'b0) begin bad++; $display("FAIL reset_fs: got %0b want 0", fs); end
    total++; if (serr !== 1'b0) begin bad++; $display("FAIL reset_syncerr: got %0b want 0", serr); end
    $display("test_reset: checked outputs under reset");
  endtask

  task automatic test_lock();
    clear_counts();
    rst_n = 1'b1;
    start_at(522, 0);
    run_until(1, 705);
    total++; if (n_lock !== 0) begin bad++; $display("FAIL lock_early: got %0d locked cycles want 0", n_lock); end
    next_pos();
    step();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_rise: got %0b want 1", locked); end
    total++; if (hpos !== 11'd706) begin bad++; $display("FAIL lock_hpos: got %0d want 706", hpos); end
    total++; if (vpos !== 11'd1) begin bad++; $display("FAIL lock_vpos: got %0d want 1", vpos); end
    $display("test_lock: lock at line %0d h %0d locked=%0b", gv, gh, locked);
  endtask

  task automatic test_position();
    clear_counts();
    chk_pos = 1'b1;
    run_until(2, 703);
    next_pos();
    step();
    total++; if (hpos !== 11'd704) begin bad++; $display("FAIL pos_after_e0: got %0d want 704", hpos); end
    run_until(2, 799);
    total++; if (n_act !== 640) begin bad++; $display("FAIL active_len: got %0d want 640", n_act); end
    total++; if (n_err !== 0) begin bad++; $display("FAIL pos_syncerr: got %0d want 0", n_err); end
    total++; if (n_fs !== 0) begin bad++; $display("FAIL pos_fs: got %0d want 0", n_fs); end
    total++; if (n_posbad !== 0) begin bad++; $display("FAIL pos_track: got %0d bad cycles want 0", n_posbad); end
    $display("test_position: active=%0d posbad=%0d", n_act, n_posbad);
  endtask

  task automatic test_long_line();
    clear_counts();
    chk_pos = 1'b0;
    run_until(3, 100);
    step();
    run_until(3, 705);
    total++; if (serr !== 1'b1) begin bad++; $display("FAIL long_miss_pulse: got %0b want 1", serr); end
    next_pos();
    step();
    total++; if (hpos !== 11'd706) begin bad++; $display("FAIL long_realign: got %0d want 706", hpos); end
    chk_pos = 1'b1;
    run_until(4, 799);
    total++; if (n_err !== 1) begin bad++; $display("FAIL long_errs: got %0d want 1", n_err); end
    total++; if (n_unl !== 0) begin bad++; $display("FAIL long_locked: got %0d unlocked cycles want 0", n_unl); end
    total++; if (n_posbad !== 0) begin bad++; $display("FAIL long_track: got %0d bad cycles want 0", n_posbad); end
    $display("test_long_line: errs=%0d", n_err);
  endtask

  task automatic test_short_lines();
    int errs;
    clear_counts();
    chk_pos = 1'b0;
    for (int line = 5; line <= 7; line++) begin
      run_until(line, 99);
      gh = 100;
      run_until(line, 706);
      total++; if (serr !== 1'b1) begin bad++; $display("FAIL short_pulse_%0d: got %0b want 1", line, serr); end
      total++; if (locked !== (line < 7)) begin bad++; $display("FAIL short_locked_%0d: got %0b want %0b", line, locked, line < 7); end
      $display("test_short_lines: line %0d serr=%0b locked=%0b", line, serr, locked);
    end
    errs = n_err;
    n_act = 0;
    run_until(8, 799);
    total++; if (errs !== 3) begin bad++; $display("FAIL short_errs: got %0d want 3", errs); end
    total++; if (n_act !== 0) begin bad++; $display("FAIL short_active: got %0d want 0", n_act); end
  endtask

  task automatic test_frame_start();
    do_reset();
    total++; if (locked !== 1'b0 || hpos !== 11'd0) begin bad++; $display("FAIL async_reset: got locked=%0b hpos=%0d want 0 0", locked, hpos); end
    chk_pos = 1'b0;
    start_at(520, 0);
    run_until(524, 706);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock: got %0b want 1", locked); end
    clear_counts();
    chk_pos = 1'b1;
    run_until(0, 0);
    total++; if (fs !== 1'b1) begin bad++; $display("FAIL fs_pulse: got %0b want 1", fs); end
    run_until(0, 799);
    total++; if (n_fs !== 1) begin bad++; $display("FAIL fs_count: got %0d want 1", n_fs); end
    total++; if (n_act !== 640) begin bad++; $display("FAIL fs_active: got %0d want 640", n_act); end
    total++; if (n_posbad !== 0) begin bad++; $display("FAIL fs_track: got %0d bad cycles want 0", n_posbad); end
    $display("test_frame_start: fs=%0d active=%0d", n_fs, n_act);
  endtask

  task automatic test_hsync_stuck();
    clear_counts();
    chk_pos = 1'b0;
    hs_stuck = 1'b1;
    for (int line = 1; line <= 3; line++) begin
      run_until(line, 706);
      total++; if (serr !== 1'b1) begin bad++; $display("FAIL stuck_pulse_%0d: got %0b want 1", line, serr); end
      total++; if (locked !== (line < 3)) begin bad++; $display("FAIL stuck_locked_%0d: got %0b want %0b", line, locked, line < 3); end
      $display("test_hsync_stuck: line %0d serr=%0b locked=%0b", line, serr, locked);
    end
    run_until(4, 0);
    hs_stuck = 1'b0;
    total++; if (n_err !== 3) begin bad++; $display("FAIL stuck_errs: got %0d want 3", n_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    chk_pos = 1'b0;
    start_at(520, 0);
    run_until(1, 300);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL b2b_prelock: got %0b want 1", locked); end
    clear_counts();
    // Jump the source so H and V sync fall together at the wrong place.
    gv = 523;
    gh = 704;
    step();
    next_pos(); step();
    next_pos(); step();
    total++; if (serr !== 1'b1) begin bad++; $display("FAIL b2b_pulse: got %0b want 1", serr); end
    total++; if (hpos !== 11'd706 || vpos !== 11'd523) begin bad++; $display("FAIL b2b_realign: got h=%0d v=%0d want 706 523", hpos, vpos); end
    total++; if (n_err !== 1) begin bad++; $display("FAIL b2b_single: got %0d pulses want 1", n_err); end
    run_until(524, 99);
    gh = 100;
    run_until(524, 706);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL b2b_second: got locked %0b want 1", locked); end
    run_until(0, 99);
    gh = 100;
    run_until(0, 706);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL b2b_third: got locked %0b want 0", locked); end
    total++; if (n_err !== 3) begin bad++; $display("FAIL b2b_errs: got %0d want 3", n_err); end
    $display("test_back_to_back: errs=%0d locked=%0b", n_err, locked);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_position();
    test_long_line();
    test_short_lines();
    test_frame_start();
    test_hsync_stuck();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
